sort_drain: RTL
===============

# sort_drain

Result-side consumer for the 4-entry sorter. It watches the sorter's parallel outputs `s0..s3` and `done`, captures a completed sort on the rising edge of `done`, and streams the four values out one per transfer over a valid/ready interface. It also flags unsorted results and results lost while a frame is still draining, and counts delivered frames. It sits between `sort` and any serial sink, such as a display scanner or UART formatter.

## Interface
- `N`, default 4: data width of each element.
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `s0`, `s1`, `s2`, `s3`  in  N each  sorter outputs; `s0` is intended to be the smallest.
- `done`  in  1  sorter completion level; a 0→1 transition marks a new result.
- `out_data`  out  N  current element.
- `out_valid`  out  1  `out_data` is valid.
- `out_ready`  in  1  sink accepts the element when `out_valid` and `out_ready` are both high.
- `out_idx`  out  2  index of the current element, 0 to 3.
- `out_last`  out  1  high with element 3.
- `busy`  out  1  a frame is captured and not yet fully drained.
- `order_err`  out  1  the last captured frame violates `s0<=s1<=s2<=s3` (unsigned comparison).
- `overrun`  out  1  sticky; a `done` rise was dropped.
- `frames`  out  8  count of fully drained frames; wraps from 255 to 0.

## Operation
- Rise detect: register `done` into `done_q`; `rise = done & ~done_q`. `done_q` resets to 0, so `done` held high at reset release counts as a rise.
- State IDLE:
  - on `rise`, load `buf[0..3] <= s0..s3`, set `idx <= 0`, and load `order_err` from the unsigned compare of `s0..s3`;
  - go to SEND.
- State SEND:
  - `out_valid = 1`, `out_data = buf[idx]`, `out_idx = idx`, `out_last = (idx==3)`.
  - On a handshake with `idx<3`: `idx <= idx+1`.
  - On a handshake with `idx==3`: `frames <= frames+1`, then go to IDLE.
- `done` rise in SEND with no final handshake in the same cycle: set `overrun`, discard the new data, and leave `buf` and `order_err` unchanged.
- `done` rise in the same cycle as the final handshake (`idx==3`): the new frame is accepted.
  - Capture it, stay in SEND with `idx <= 0`, and increment `frames`.
  - `overrun` is not set.
- Flag lifetimes:
  - `order_err` holds until the next capture.
  - `overrun` clears only on reset.
- `out_data`, `out_idx` and `out_last` are 0 whenever `out_valid` is 0.
- Stable-data rule: while `out_valid` is high and `out_ready` is low, `out_data`, `out_idx` and `out_last` hold steady.

## Timing
- Reset values (asynchronous, immediate on `rst_n` low):
  - state IDLE;
  - `out_valid`, `out_last`, `busy`, `order_err`, `overrun` = 0;
  - `out_data`, `out_idx`, `buf`, `frames`, `done_q` = 0.
- Latency: `done` is first sampled high at edge k. The buffer loads at edge k, and `out_valid` is high in the cycle after edge k.
- Throughput: with `out_ready` tied high, one element per cycle. A frame occupies exactly 4 cycles of `out_valid`.
- `busy` equals `out_valid`; both are registered-state decodes with no combinational path from `out_ready`.
- `out_ready` may toggle arbitrarily. The block holds its data until the handshake occurs.
- Reset mid-frame: the partial frame is abandoned, is not counted in `frames`, and no element is re-sent after reset.

## Structure
- Package `sort_pkg` holds:
  - the state encoding: `ST_IDLE = 1'b0`, `ST_SEND = 1'b1`;
  - `SORT_LANES = 4`;
  - `IDX_W = 2`;
  - `FRAME_W = 8`.
- Sub-module `rise_det` is a 1-bit edge detector with an async active-low reset. It outputs `rise` and is reusable for `done` elsewhere.
- The rest is flat: a 4×N buffer, a 2-bit index, a 2-state FSM, an unsigned 3-compare checker, and the flags and counter.

## Test plan
- Basic frame: `s=3,7,6,1`, `done` rises, `out_ready=1` → `out_data` sequence 3,7,6,1; `order_err=1`; `out_last` on the 4th element; `frames=1`.
- Sorted frame with backpressure: `s=1,3,6,7`, `out_ready` alternating 0/1 → 1,3,6,7 delivered with data stable while stalled; `order_err=0`; 7 cycles of `out_valid`.
- Overrun: `s=4,8,10,15` capture, `out_ready=0`, then pulse `done` with `s=2,4,6,9` → `overrun=1`; output still 4,8,10,15; `frames=1` after the drain.
- Back-to-back: `done` rise coincident with the `idx==3` handshake → no overrun, next element is the new `s0` immediately, `frames` increments.
- Reset mid-frame: `rst_n` low after 2 of 4 elements → all outputs 0 immediately; after release, with `done` high, the current `s0..s3` are captured and `frames=0`.
- Wrap: 256 sorted frames → `frames` returns to 0; `order_err=0` throughout.

Source files
------------

// File: rtl/sort_pkg.sv
// Shared encodings and sizes for the sorter result-side logic.
package sort_pkg;

  localparam int SORT_LANES = 4;
  localparam int IDX_W      = 2;
  localparam int FRAME_W    = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

endpackage

// File: rtl/sort_drain_rise_det.sv
// 1-bit rising-edge detector; the registered copy resets low so a level
// already high when reset releases is reported as a rise.
module rise_det (
  input  logic clk,
  input  logic rst_n,
  input  logic sig,
  output logic rise
);

  logic sig_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sig_q <= 1'b0;
    else        sig_q <= sig;
  end

  assign rise = sig & ~sig_q;

endmodule

// File: rtl/sort_drain.sv
// Captures a finished sort on done rising and streams the four lanes out
// over valid/ready, flagging unsorted frames and dropped results.
//
// state   | meaning
// ST_IDLE | no frame held, waiting for a done rise
// ST_SEND | frame held, presenting data_buf[idx]
module sort_drain
  import sort_pkg::*;
#(
  parameter int N = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N-1:0]       s0,
  input  logic [N-1:0]       s1,
  input  logic [N-1:0]       s2,
  input  logic [N-1:0]       s3,
  input  logic               done,
  output logic [N-1:0]       out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [IDX_W-1:0]   out_idx,
  output logic               out_last,
  output logic               busy,
  output logic               order_err,
  output logic               overrun,
  output logic [FRAME_W-1:0] frames
);

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(SORT_LANES - 1);

  state_t                     state, state_nx;
  logic [SORT_LANES-1:0][N-1:0] data_buf;
  logic [IDX_W-1:0]           idx;
  logic                       rise;
  logic                       hs;
  logic                       capture;
  logic                       advance;
  logic                       frame_end;
  logic                       drop;
  logic                       in_order;

  rise_det u_rise_det (
    .clk   (clk),
    .rst_n (rst_n),
    .sig   (done),
    .rise  (rise)
  );

  assign in_order = (s0 <= s1) && (s1 <= s2) && (s2 <= s3);
  assign hs       = (state == ST_SEND) && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    capture   = 1'b0;
    advance   = 1'b0;
    frame_end = 1'b0;
    drop      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (rise) begin
          capture  = 1'b1;
          state_nx = ST_SEND;
        end
      end
      ST_SEND: begin
        if (hs && (idx == IDX_LAST)) begin
          frame_end = 1'b1;
          // a rise on the final handshake chains straight into the next frame
          if (rise) capture  = 1'b1;
          else      state_nx = ST_IDLE;
        end else begin
          if (hs)   advance = 1'b1;
          if (rise) drop    = 1'b1;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_buf  <= '0;
      idx       <= '0;
      order_err <= 1'b0;
      overrun   <= 1'b0;
      frames    <= '0;
    end else begin
      if (capture) begin
        data_buf  <= {s3, s2, s1, s0};
        idx       <= '0;
        order_err <= ~in_order;
      end else if (advance) begin
        idx <= idx + 1'b1;
      end
      if (frame_end) frames  <= frames + 1'b1;
      if (drop)      overrun <= 1'b1;
    end
  end

  assign out_valid = (state == ST_SEND);
  assign busy      = out_valid;
  assign out_data  = out_valid ? data_buf[idx] : '0;
  assign out_idx   = out_valid ? idx : '0;
  assign out_last  = out_valid && (idx == IDX_LAST);

endmodule
